// File: rtl/fifo_pkg.sv
// Shared width helpers for the parallel-lane FIFO and its pointer arithmetic.
package fifo_pkg;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an index into n entries; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_ptr_adv.sv
// Circular pointer advance: ptr + k, wrapped into 0..SIZE-1 by one conditional
// subtraction. k never exceeds SIZE, so the wrap is correct for any depth,
// including depths that are not a power of two.
module fifo_ptr_adv
    import fifo_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int K_W  = 4
)(
    input  logic [ptr_w(SIZE)-1:0] ptr,
    input  logic [K_W-1:0]         k,
    output logic [ptr_w(SIZE)-1:0] ptr_nxt
);

    localparam int PTR_W = ptr_w(SIZE);
    localparam int SUM_W = ((PTR_W > K_W) ? PTR_W : K_W) + 1;

    logic [SUM_W-1:0] sum;

    // Add, then fold back once if the sum runs past the end of storage.
    always_comb begin
        sum = SUM_W'(ptr) + SUM_W'(k);
        if (sum >= SUM_W'(SIZE)) begin
            ptr_nxt = PTR_W'(sum - SUM_W'(SIZE));
        end else begin
            ptr_nxt = PTR_W'(sum);
        end
    end

endmodule

// File: rtl/par_fifo_var.sv
// Multi-lane circular FIFO. Each cycle the write port may push 0..PAR_WRITE
// words and the read port may pop 0..PAR_READ words. Both handshakes are
// judged against the registered fill level only, so a read never frees
// space for a same-cycle write and a written word is readable one cycle later.
module par_fifo_var
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 8,
    parameter int PAR_WRITE  = 4,
    parameter int PAR_READ   = 4,
    parameter int AF_THRESH  = SIZE - PAR_WRITE,
    parameter int AE_THRESH  = PAR_READ
)(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  wr_valid,
    input  logic [cnt_w(PAR_WRITE)-1:0]           wr_count,
    input  logic [PAR_WRITE-1:0][DATA_WIDTH-1:0]  wr_data,
    output logic                                  wr_ready,
    input  logic                                  rd_ready,
    input  logic [cnt_w(PAR_READ)-1:0]            rd_count,
    output logic                                  rd_valid,
    output logic [PAR_READ-1:0][DATA_WIDTH-1:0]   rd_data,
    output logic [cnt_w(SIZE)-1:0]                fill_level,
    output logic                                  full,
    output logic                                  empty,
    output logic                                  almost_full,
    output logic                                  almost_empty,
    output logic                                  overflow
);

    localparam int WC_W  = cnt_w(PAR_WRITE);
    localparam int RC_W  = cnt_w(PAR_READ);
    localparam int PTR_W = ptr_w(SIZE);
    localparam int LVL_W = cnt_w(SIZE);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t            mem [SIZE];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] wr_addr [PAR_WRITE];
    logic [PTR_W-1:0] rd_addr [PAR_READ];
    logic             wr_acc;
    logic             rd_acc;
    logic             wr_over;
    logic [LVL_W-1:0] wr_words;
    logic [LVL_W-1:0] rd_words;

    // Handshakes and accepted word counts, all from the pre-edge fill level.
    always_comb begin
        wr_ready = (SIZE - int'(fill_level)) >= int'(wr_count);
        rd_valid = int'(fill_level) >= int'(rd_count);
        wr_acc   = wr_valid && wr_ready && (wr_count != '0);
        rd_acc   = rd_ready && rd_valid && (rd_count != '0);
        wr_over  = wr_valid && !wr_ready;
        wr_words = wr_acc ? LVL_W'(wr_count) : '0;
        rd_words = rd_acc ? LVL_W'(rd_count) : '0;
    end

    fifo_ptr_adv #(.SIZE(SIZE), .K_W(WC_W)) u_wr_adv (
        .ptr     (wr_ptr),
        .k       (wr_count),
        .ptr_nxt (wr_ptr_nxt)
    );

    fifo_ptr_adv #(.SIZE(SIZE), .K_W(RC_W)) u_rd_adv (
        .ptr     (rd_ptr),
        .k       (rd_count),
        .ptr_nxt (rd_ptr_nxt)
    );

    // Per-lane storage addresses: write lane i lands at wr_ptr+i, read lane i
    // shows rd_ptr+i, both wrapped.
    for (genvar i = 0; i < PAR_WRITE; i++) begin : g_wr_lane
        fifo_ptr_adv #(.SIZE(SIZE), .K_W(WC_W)) u_wr_lane (
            .ptr     (wr_ptr),
            .k       (WC_W'(i)),
            .ptr_nxt (wr_addr[i])
        );
    end

    for (genvar i = 0; i < PAR_READ; i++) begin : g_rd_lane
        fifo_ptr_adv #(.SIZE(SIZE), .K_W(RC_W)) u_rd_lane (
            .ptr     (rd_ptr),
            .k       (RC_W'(i)),
            .ptr_nxt (rd_addr[i])
        );
    end

    // Pointer, level and sticky error state; flush beats any same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_nxt;
            end
            fill_level <= fill_level + wr_words - rd_words;
            if (wr_over) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage write of the accepted lanes; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                if (i < int'(wr_count)) begin
                    mem[wr_addr[i]] <= wr_data[i];
                end
            end
        end
    end

    // Show-ahead read lanes; lanes beyond the stored word count read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < PAR_READ; i++) begin
            if (i < int'(fill_level)) begin
                rd_data[i] = mem[rd_addr[i]];
            end
        end
    end

    // Status flags decoded from the registered fill level.
    always_comb begin
        full         = (fill_level == LVL_W'(SIZE));
        empty        = (fill_level == '0);
        almost_full  = int'(fill_level) >= AF_THRESH;
        almost_empty = int'(fill_level) < AE_THRESH;
    end

endmodule
